// File: rtl/cnn_pkg.sv
// cnn_pkg -- shared definitions for the CNN MAC engine.
// Holds the default datapath widths and the controller state type used by
// cnn_mac_engine and cnn_sat16.
package cnn_pkg;

  localparam int P_DATA_W = 16;  // memory word / pixel / weight / result width
  localparam int P_ADDR_W = 8;   // RAM address width (256 words)
  localparam int P_ACC_W  = 40;  // signed accumulator width
  localparam int P_FRAC   = 8;   // fractional bits of the Q8.8 format

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_IMG = 3'd1,
    RD_WGT = 3'd2,
    MAC    = 3'd3,
    OUT    = 3'd4
  } state_t;

endpackage

// File: rtl/cnn_sat16.sv
// cnn_sat16 -- combinational rescale and saturate of the accumulator.
// Ports:
//   acc    in  : signed accumulator (ACC_W bits, 2*FRAC fractional bits)
//   result out : acc >>> FRAC clipped to the signed DATA_W range
//   sat    out : high when clipping took place
module cnn_sat16
  import cnn_pkg::*;
#(
  parameter int DATA_W = P_DATA_W,
  parameter int ACC_W  = P_ACC_W,
  parameter int FRAC   = P_FRAC
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] result,
  output logic                     sat
);

  // Largest and smallest representable DATA_W values, extended to ACC_W.
  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  // Arithmetic shift truncates towards minus infinity, then clip.
  always_comb begin
    shifted = acc >>> FRAC;
    result  = shifted[DATA_W-1:0];
    sat     = 1'b0;
    if (shifted > MAX_V) begin
      result = MAX_V[DATA_W-1:0];
      sat    = 1'b1;
    end else if (shifted < MIN_V) begin
      result = MIN_V[DATA_W-1:0];
      sat    = 1'b1;
    end else begin
      result = shifted[DATA_W-1:0];
      sat    = 1'b0;
    end
  end

endmodule

// File: rtl/cnn_mac_engine.sv
// cnn_mac_engine -- sequential Q8.8 dot product over a single-port RAM.
// Reads pixel[i] and weight[i] alternately (1-cycle read latency), accumulates
// their products, then presents the rescaled, saturated result with a
// valid/ready handshake.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, img_base,
//   wgt_base, len         : operation request (sampled in IDLE only)
//   busy                  : high whenever not IDLE
//   mem_rd_en, mem_addr,
//   mem_rdata             : RAM read port, data valid 1 cycle after rd_en
//   result, sat           : Q8.8 dot product and clip flag
//   result_valid,
//   result_ready, done    : result handshake, done pulses on acceptance
module cnn_mac_engine
  import cnn_pkg::*;
#(
  parameter int DATA_W = P_DATA_W,
  parameter int ADDR_W = P_ADDR_W,
  parameter int ACC_W  = P_ACC_W,
  parameter int FRAC   = P_FRAC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [7:0]        len,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] result,
  output logic              sat,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              done
);

  state_t state, state_next;

  logic [ADDR_W-1:0]        img_base_r, wgt_base_r;
  logic [7:0]               len_r, idx;
  logic signed [DATA_W-1:0] pixel;
  logic signed [ACC_W-1:0]  acc;
  logic [DATA_W-1:0]        result_r;
  logic                     sat_r, valid_r;

  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          sat_result;
  logic                       sat_flag;

  assign prod = pixel * $signed(mem_rdata);

  cnn_sat16 #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .FRAC   (FRAC)
  ) u_sat (
    .acc    (acc),
    .result (sat_result),
    .sat    (sat_flag)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (len == 8'd0) ? OUT : RD_IMG;
        else       state_next = IDLE;
      end
      RD_IMG: state_next = RD_WGT;
      RD_WGT: state_next = MAC;
      MAC: begin
        if ((idx + 8'd1) == len_r) state_next = OUT;
        else                       state_next = RD_IMG;
      end
      OUT: begin
        // Only a presented result can be accepted; the first OUT cycle loads it.
        if (valid_r && result_ready) state_next = IDLE;
        else                         state_next = OUT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, accumulation and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      img_base_r <= '0;
      wgt_base_r <= '0;
      len_r      <= 8'd0;
      idx        <= 8'd0;
      pixel      <= '0;
      acc        <= '0;
      result_r   <= '0;
      sat_r      <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            img_base_r <= img_base;
            wgt_base_r <= wgt_base;
            len_r      <= len;
            idx        <= 8'd0;
            acc        <= '0;
          end
        end
        RD_WGT: pixel <= $signed(mem_rdata);
        MAC: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + 8'd1;
        end
        OUT: begin
          if (!valid_r) begin
            result_r <= sat_result;
            sat_r    <= sat_flag;
            valid_r  <= 1'b1;
          end else if (result_ready) begin
            valid_r  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Read port: pixel address in RD_IMG, weight address in RD_WGT.
  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    if (!reset) begin
      case (state)
        RD_IMG: begin
          mem_rd_en = 1'b1;
          mem_addr  = img_base_r + ADDR_W'(idx);
        end
        RD_WGT: begin
          mem_rd_en = 1'b1;
          mem_addr  = wgt_base_r + ADDR_W'(idx);
        end
        default: begin
          mem_rd_en = 1'b0;
          mem_addr  = '0;
        end
      endcase
    end
  end

  // Status and result outputs, forced low while reset is held.
  assign busy         = !reset && (state != IDLE);
  assign result_valid = !reset && valid_r;
  assign result       = reset ? '0 : result_r;
  assign sat          = !reset && sat_r;
  assign done         = !reset && (state == OUT) && valid_r && result_ready;

endmodule

// File: tb/tb_cnn_mac_engine.sv
// tb_cnn_mac_engine -- directed self-checking bench for cnn_mac_engine.
// A behavioural RAM answers reads one cycle late; a plain-arithmetic model
// gives the expected result, and a queue gives the expected read addresses.
module tb_cnn_mac_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  img_base, wgt_base, len;
  logic        busy, mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] result;
  logic        sat, result_valid, result_ready, done;

  cnn_mac_engine dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .img_base     (img_base),
    .wgt_base     (wgt_base),
    .len          (len),
    .busy         (busy),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .result       (result),
    .sat          (sat),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .done         (done)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [0:255];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_res = 16'd0;
  logic        exp_sat = 1'b0;
  logic [15:0] got_r;
  logic        got_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Dot product straight from the arithmetic definition.
  function automatic void model(input logic [7:0] ib, input logic [7:0] wb, input int n,
                                output logic [15:0] r, output logic s);
    longint sum = 0;
    longint q;
    logic [7:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = ib + 8'(i);
      b = wb + 8'(i);
      sum += longint'($signed(ram[a])) * longint'($signed(ram[b]));
    end
    q = sum >>> 8;
    if (q > 64'sd32767)       begin r = 16'h7FFF; s = 1'b1; end
    else if (q < -64'sd32768) begin r = 16'h8000; s = 1'b1; end
    else                      begin r = q[15:0];  s = 1'b0; end
  endfunction

  // Every-cycle comparison of read addresses and presented result.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd_en) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_unexpected: got read at 0x%0h expected no read", mem_addr);
        end else begin
          chk("rd_addr", {24'd0, mem_addr}, {24'd0, exp_q.pop_front()});
        end
      end
      if (result_valid) begin
        chk("result", {16'd0, result}, {16'd0, exp_res});
        chk("sat", {31'd0, sat}, {31'd0, exp_sat});
      end
      if (done) done_cnt++;
    end
  end

  // One operation; entered and left just after a rising edge.
  task automatic run_op(input logic [7:0] ib, input logic [7:0] wb, input logic [7:0] ln,
                        input int hold, input logic poke,
                        output logic [15:0] r, output logic s);
    int cyc;
    model(ib, wb, int'(ln), exp_res, exp_sat);
    exp_q.delete();
    for (int i = 0; i < int'(ln); i++) begin
      exp_q.push_back(ib + 8'(i));
      exp_q.push_back(wb + 8'(i));
    end
    done_cnt = 0;
    img_base = ib; wgt_base = wb; len = ln; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (result_valid) break;
      cyc++;
      if (poke) begin
        // A request while busy must be ignored.
        start    = (cyc == 3);
        img_base = 8'h00;
        len      = 8'd7;
      end
    end
    start = 1'b0;
    chk("valid_cycle", cyc, 32'd3 * {24'd0, ln} + 32'd2);
    r = result;
    s = sat;
    chk("busy_in_out", {31'd0, busy}, 32'd1);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 result_ready = 1'b1; start = poke;
    @(negedge clk);
    chk("done_at_handshake", {31'd0, done}, 32'd1);
    @(posedge clk); #1 result_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_after", {31'd0, busy}, 32'd0);
    chk("done_count", done_cnt, 32'd1);
    chk("reads_consumed", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    ram[8'h10] = 16'h0100; ram[8'h20] = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      ram[8'h30 + i] = 16'h7FFF;
      ram[8'h40 + i] = 16'h7FFF;
      ram[8'h50 + i] = 16'h8000;
    end
    ram[8'hFE] = 16'h0100; ram[8'hFF] = 16'h0200; ram[8'h00] = 16'hFF00;
    ram[8'h60] = 16'h0080; ram[8'h61] = 16'h0100; ram[8'h62] = 16'h0300;
    ram[8'h70] = 16'hFFFF; ram[8'h71] = 16'h0001;

    reset = 1'b1; start = 1'b0; result_ready = 1'b0;
    img_base = 8'd0; wgt_base = 8'd0; len = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_outs", {8'd0, mem_addr, result}, 32'd0);
    chk("rst_flags", {29'd0, sat, result_valid, done}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single pair, start in the first cycle after reset.
    run_op(8'h10, 8'h20, 8'd1, 0, 1'b0, got_r, got_s);
    chk("lit_single", {15'd0, got_s, got_r}, 32'h0000_0200);
    chk("model_single", {15'd0, exp_sat, exp_res}, 32'h0000_0200);

    // len = 0: no reads, result in cycle 2.
    run_op(8'h10, 8'h20, 8'd0, 0, 1'b0, got_r, got_s);
    chk("lit_len0", {15'd0, got_s, got_r}, 32'h0000_0000);

    // Positive and negative saturation.
    run_op(8'h30, 8'h40, 8'd4, 0, 1'b0, got_r, got_s);
    chk("lit_sat_pos", {15'd0, got_s, got_r}, 32'h0001_7FFF);
    chk("model_sat_pos", {15'd0, exp_sat, exp_res}, 32'h0001_7FFF);
    run_op(8'h50, 8'h40, 8'd4, 0, 1'b0, got_r, got_s);
    chk("lit_sat_neg", {15'd0, got_s, got_r}, 32'h0001_8000);
    chk("model_sat_neg", {15'd0, exp_sat, exp_res}, 32'h0001_8000);

    // Address wrap 0xFE, 0xFF, 0x00: 0.5 + 2.0 - 3.0 = -0.5.
    run_op(8'hFE, 8'h60, 8'd3, 0, 1'b0, got_r, got_s);
    chk("lit_wrap", {15'd0, got_s, got_r}, 32'h0000_FF80);
    chk("model_wrap", {15'd0, exp_sat, exp_res}, 32'h0000_FF80);

    // -1 LSB^2 truncates down to -1 LSB.
    run_op(8'h70, 8'h71, 8'd1, 0, 1'b0, got_r, got_s);
    chk("lit_trunc", {15'd0, got_s, got_r}, 32'h0000_FFFF);

    // Backpressure with stray starts, including on the handshake cycle.
    run_op(8'hFE, 8'h60, 8'd3, 5, 1'b1, got_r, got_s);
    chk("lit_backpressure", {15'd0, got_s, got_r}, 32'h0000_FF80);

    // Reset while in RD_WGT.
    exp_q.delete();
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h40);
    done_cnt = 0;
    img_base = 8'h30; wgt_base = 8'h40; len = 8'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("abort_outs", {8'd0, mem_addr, result}, 32'd0);
    chk("abort_flags", {29'd0, sat, result_valid, done}, 32'd0);
    chk("abort_no_done", done_cnt, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    run_op(8'h10, 8'h20, 8'd1, 0, 1'b0, got_r, got_s);
    chk("lit_after_abort", {15'd0, got_s, got_r}, 32'h0000_0200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
